// File: rtl/dom_and_sched_if.sv
// dom_and_sched_if
//   Bundles every non-clock signal of the DOM AND issue controller.
//   slave  : the controller (dom_and_sched)
//   master : its environment (sequencer, PRNG, gadget)
//   Operand side   : InValidSI/InReadySO, LeftDI, RightDI
//   Randomness side: RandValidSI/RandReadySO, RandDI, RandLevelDO
//   Gadget side    : GadLeftDO, GadRightDO, GadRandomDO, GadOutDI
//   Result side    : OutValidSO/OutReadySI, OutDO
interface dom_and_sched_if #(
    parameter int NUM_SHARES = 2,
    parameter int RAND_DEPTH = 4
);
    localparam int NUM_MASKS = (NUM_SHARES - 1) * NUM_SHARES / 2;
    localparam int LVL_W     = $clog2(RAND_DEPTH + 1);

    logic                  InValidSI;
    logic                  InReadySO;
    logic [NUM_SHARES-1:0] LeftDI;
    logic [NUM_SHARES-1:0] RightDI;
    logic                  RandValidSI;
    logic                  RandReadySO;
    logic [NUM_MASKS-1:0]  RandDI;
    logic [NUM_SHARES-1:0] GadLeftDO;
    logic [NUM_SHARES-1:0] GadRightDO;
    logic [NUM_MASKS-1:0]  GadRandomDO;
    logic [NUM_SHARES-1:0] GadOutDI;
    logic                  OutValidSO;
    logic                  OutReadySI;
    logic [NUM_SHARES-1:0] OutDO;
    logic [LVL_W-1:0]      RandLevelDO;

    modport slave (
        input  InValidSI, LeftDI, RightDI, RandValidSI, RandDI, GadOutDI, OutReadySI,
        output InReadySO, RandReadySO, GadLeftDO, GadRightDO, GadRandomDO,
               OutValidSO, OutDO, RandLevelDO
    );

    modport master (
        output InValidSI, LeftDI, RightDI, RandValidSI, RandDI, GadOutDI, OutReadySI,
        input  InReadySO, RandReadySO, GadLeftDO, GadRightDO, GadRandomDO,
               OutValidSO, OutDO, RandLevelDO
    );
endinterface

// File: rtl/dom_and_sched.sv
// dom_and_sched
//   Issue controller for one shared registered DOM AND gadget (1-cycle
//   latency). Operand pairs are issued only when an unused randomness word
//   sits in the local FIFO; each word is popped by exactly one issue. The
//   gadget result is captured and held on a valid/ready output.
// Ports
//   ClkCI  : clock, rising edge
//   RstRI  : asynchronous reset, active low
//   bus    : dom_and_sched_if.slave (operand, randomness, gadget, result)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for an operand pair; issues it when a word is queued
// ST_EVAL | gadget is computing; its output is captured at the next edge
// ST_HOLD | result presented on OutDO/OutValidSO until OutReadySI
module dom_and_sched #(
    parameter int NUM_SHARES = 2,
    parameter int RAND_DEPTH = 4
) (
    input  logic           ClkCI,
    input  logic           RstRI,
    dom_and_sched_if.slave bus
);
    localparam int NUM_MASKS = (NUM_SHARES - 1) * NUM_SHARES / 2;
    localparam int LVL_W     = $clog2(RAND_DEPTH + 1);
    localparam int PTR_W     = (RAND_DEPTH > 1) ? $clog2(RAND_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [NUM_MASKS-1:0]  r_mem [RAND_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [NUM_SHARES-1:0] r_out;

    logic                  w_rand_ready;
    logic                  w_push;
    logic                  w_not_empty;
    logic                  w_in_ready;
    logic                  w_issue;
    logic                  w_capture;
    logic [NUM_SHARES-1:0] w_gad_left;
    logic [NUM_SHARES-1:0] w_gad_right;
    logic [NUM_MASKS-1:0]  w_gad_rand;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RAND_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Fullness is judged on the registered level, so a pop in the same
    // cycle never frees room for a push; RstRI gates ready during reset.
    assign w_rand_ready = RstRI & (r_level != LVL_W'(RAND_DEPTH));
    assign w_push       = bus.RandValidSI & w_rand_ready;
    assign w_not_empty  = (r_level != '0);

    // Storage is not reset: contents are only read when the level says so.
    always_ff @(posedge ClkCI) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.RandDI;
        end
    end

    always_ff @(posedge ClkCI or negedge RstRI) begin
        if (!RstRI) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_issue) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_issue})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge ClkCI or negedge RstRI) begin
        if (!RstRI) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Gadget inputs are forced to zero outside the issue cycle so that old
    // shares never meet fresh ones inside the gadget registers.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_gad_left  = '0;
        w_gad_right = '0;
        w_gad_rand  = '0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = w_not_empty;
                w_issue    = bus.InValidSI & w_not_empty;
                if (w_issue) begin
                    w_gad_left  = bus.LeftDI;
                    w_gad_right = bus.RightDI;
                    w_gad_rand  = r_mem[r_rd_ptr];
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.OutReadySI) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ClkCI or negedge RstRI) begin
        if (!RstRI) begin
            r_out <= '0;
        end else if (w_capture) begin
            r_out <= bus.GadOutDI;
        end
    end

    assign bus.InReadySO   = w_in_ready;
    assign bus.RandReadySO = w_rand_ready;
    assign bus.GadLeftDO   = w_gad_left;
    assign bus.GadRightDO  = w_gad_right;
    assign bus.GadRandomDO = w_gad_rand;
    assign bus.OutValidSO  = (r_state == ST_HOLD);
    assign bus.OutDO       = r_out;
    assign bus.RandLevelDO = r_level;
endmodule

// File: tb/tb_dom_and_sched.sv
// tb_dom_and_sched
//   Directed steps followed by a random phase. A queue holds the randomness
//   words the controller should own; a pending-result record derived from the
//   accept cycle gives the expected handshake and output timing. The gadget is
//   modelled as a registered DOM AND.
module tb_dom_and_sched;
    localparam int NS    = 2;
    localparam int DEPTH = 4;
    localparam int NM    = (NS - 1) * NS / 2;

    logic clk;
    logic rst_n;

    dom_and_sched_if #(.NUM_SHARES(NS), .RAND_DEPTH(DEPTH)) bus ();

    dom_and_sched #(.NUM_SHARES(NS), .RAND_DEPTH(DEPTH)) dut (
        .ClkCI (clk),
        .RstRI (rst_n),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [NM-1:0] mq[$];
    logic          busy    = 1'b0;
    int            acc_cyc = -10;
    int            cyc_no  = 0;
    logic [NS-1:0] exp_res = '0;
    logic [NS-1:0] exp_out = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DOM AND: inner-domain products plus cross-domain products each
    // blinded by the pair's shared mask.
    function automatic logic [NS-1:0] dom_and(input logic [NS-1:0] x,
                                              input logic [NS-1:0] y,
                                              input logic [NM-1:0] z);
        logic [NS-1:0] o;
        int k;
        o = '0;
        for (int i = 0; i < NS; i++) o[i] = x[i] & y[i];
        k = 0;
        for (int i = 0; i < NS; i++) begin
            for (int j = i + 1; j < NS; j++) begin
                o[i] ^= (x[i] & y[j]) ^ z[k];
                o[j] ^= (x[j] & y[i]) ^ z[k];
                k++;
            end
        end
        return o;
    endfunction

    always @(posedge clk) begin
        bus.GadOutDI <= dom_and(bus.GadLeftDO, bus.GadRightDO, bus.GadRandomDO);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        busy    = 1'b0;
        exp_out = '0;
    endtask

    // One clock: check at the falling edge, advance the model at the rising
    // edge, return 1 time unit later so the caller can drive new inputs.
    task automatic cyc();
        logic exp_rr, exp_ir, exp_ov, iss, psh;
        @(negedge clk);
        if (!rst_n) model_clear();
        exp_rr = rst_n && (mq.size() != DEPTH);
        exp_ir = rst_n && !busy && (mq.size() != 0);
        exp_ov = busy && (cyc_no >= acc_cyc + 2);
        chk("rand_ready", 32'(bus.RandReadySO), 32'(exp_rr));
        chk("in_ready",   32'(bus.InReadySO),   32'(exp_ir));
        chk("out_valid",  32'(bus.OutValidSO),  32'(exp_ov));
        chk("rand_level", 32'(bus.RandLevelDO), 32'(mq.size()));
        chk("out_do",     32'(bus.OutDO),       32'(exp_out));
        iss = bus.InValidSI && exp_ir;
        if (iss) begin
            chk("gad_left",  32'(bus.GadLeftDO),   32'(bus.LeftDI));
            chk("gad_right", 32'(bus.GadRightDO),  32'(bus.RightDI));
            chk("gad_rand",  32'(bus.GadRandomDO), 32'(mq[0]));
        end else begin
            chk("gad_left_idle",  32'(bus.GadLeftDO),   32'd0);
            chk("gad_right_idle", 32'(bus.GadRightDO),  32'd0);
            chk("gad_rand_idle",  32'(bus.GadRandomDO), 32'd0);
        end
        @(posedge clk);
        if (rst_n) begin
            psh = bus.RandValidSI && exp_rr;
            if (exp_ov && bus.OutReadySI) busy = 1'b0;
            if (iss) begin
                exp_res = dom_and(bus.LeftDI, bus.RightDI, mq.pop_front());
                busy    = 1'b1;
                acc_cyc = cyc_no;
            end
            if (psh) mq.push_back(bus.RandDI);
            if (busy && (cyc_no == acc_cyc + 1)) exp_out = exp_res;
        end
        cyc_no++;
        #1;
    endtask

    initial begin
        logic [NM-1:0] seq [4];
        seq[0] = NM'(1); seq[1] = NM'(0); seq[2] = NM'(1); seq[3] = NM'(1);

        rst_n           = 1'b0;
        bus.InValidSI   = 1'b0;
        bus.LeftDI      = '0;
        bus.RightDI     = '0;
        bus.RandValidSI = 1'b1;
        bus.RandDI      = NM'(1);
        bus.OutReadySI  = 1'b0;
        #1;
        chk("rst_rand_ready", 32'(bus.RandReadySO), 32'd0);
        chk("rst_in_ready",   32'(bus.InReadySO),   32'd0);
        chk("rst_out_valid",  32'(bus.OutValidSO),  32'd0);
        chk("rst_out_do",     32'(bus.OutDO),       32'd0);
        chk("rst_level",      32'(bus.RandLevelDO), 32'd0);
        repeat (3) cyc();

        // Fill the FIFO with 1,0,1,1 straight out of reset.
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.RandDI = seq[i];
            cyc();
        end
        chk("full_level",      32'(bus.RandLevelDO), 32'd4);
        chk("full_rand_ready", 32'(bus.RandReadySO), 32'd0);

        // Issue while full with a push offered: push refused, level 4 -> 3.
        bus.RandDI    = NM'(1);
        bus.LeftDI    = 2'b10;
        bus.RightDI   = 2'b01;
        bus.InValidSI = 1'b1;
        #2;
        chk("dir_in_ready", 32'(bus.InReadySO),   32'd1);
        chk("dir_gad_left", 32'(bus.GadLeftDO),   32'b10);
        chk("dir_gad_rand", 32'(bus.GadRandomDO), 32'd1);
        cyc();
        chk("dir_level_pop", 32'(bus.RandLevelDO), 32'd3);
        bus.InValidSI = 1'b0;
        cyc();
        chk("dir_level_refill", 32'(bus.RandLevelDO), 32'd4);
        chk("dir_out_valid",    32'(bus.OutValidSO),  32'd1);
        chk("dir_out_do",       32'(bus.OutDO),       32'b01);

        // Second op waits while the result is not consumed.
        bus.InValidSI = 1'b1;
        bus.LeftDI    = 2'b11;
        bus.RightDI   = 2'b10;
        repeat (5) cyc();
        chk("hold_out_do", 32'(bus.OutDO),     32'b01);
        chk("hold_no_acc", 32'(bus.InReadySO), 32'd0);
        bus.OutReadySI = 1'b1;
        cyc();
        bus.OutReadySI = 1'b0;
        #2;
        chk("b2b_in_ready", 32'(bus.InReadySO), 32'd1);
        cyc();
        bus.InValidSI  = 1'b0;
        bus.OutReadySI = 1'b1;
        repeat (3) cyc();

        // Drain the FIFO through successive ops with no new randomness.
        bus.RandValidSI = 1'b0;
        bus.InValidSI   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.LeftDI  = NS'($urandom);
            bus.RightDI = NS'($urandom);
            cyc();
        end
        chk("drain_level", 32'(bus.RandLevelDO), 32'd0);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("empty_in_ready", 32'(bus.InReadySO), 32'd0);
            cyc();
        end
        bus.RandValidSI = 1'b1;
        bus.RandDI      = NM'($urandom);
        #2;
        chk("no_bypass", 32'(bus.InReadySO), 32'd0);
        cyc();
        bus.RandValidSI = 1'b0;
        #2;
        chk("push_then_ready", 32'(bus.InReadySO), 32'd1);
        cyc();
        bus.InValidSI = 1'b0;
        repeat (3) cyc();

        // Random traffic on all handshakes.
        for (int i = 0; i < 400; i++) begin
            bus.RandValidSI = 1'($urandom_range(0, 1));
            bus.RandDI      = NM'($urandom);
            bus.InValidSI   = ($urandom_range(0, 9) < 7);
            bus.LeftDI      = NS'($urandom);
            bus.RightDI     = NS'($urandom);
            bus.OutReadySI  = 1'($urandom_range(0, 1));
            cyc();
        end

        // Reach HOLD, then pulse reset asynchronously.
        bus.RandValidSI = 1'b1;
        bus.InValidSI   = 1'b1;
        bus.OutReadySI  = 1'b0;
        repeat (12) cyc();
        chk("pre_rst_hold", 32'(bus.OutValidSO), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid",  32'(bus.OutValidSO),  32'd0);
        chk("mid_rst_out_do",     32'(bus.OutDO),       32'd0);
        chk("mid_rst_level",      32'(bus.RandLevelDO), 32'd0);
        chk("mid_rst_rand_ready", 32'(bus.RandReadySO), 32'd0);
        chk("mid_rst_in_ready",   32'(bus.InReadySO),   32'd0);
        model_clear();
        cyc();
        rst_n = 1'b1;
        bus.OutReadySI = 1'b1;
        repeat (10) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dom_and_sched.md
Name: dom_and_sched

Overview:
- Issue controller for one shared, registered DOM AND gadget instance (1-cycle latency, registers every clock, no enable).
- Accepts masked operand pairs over a valid/ready handshake.
- Buffers fresh randomness in a small FIFO. Issues an operation to the gadget only when one unused randomness word is available; each word is consumed exactly once.
- Captures the gadget result and holds it on a valid/ready output. Sits between the masked-datapath sequencer, the PRNG and the gadget.

Parameters:
- NUM_SHARES, 2, number of shares per operand (>=2).
- RAND_DEPTH, 4, randomness FIFO depth in words (>=1).
- NUM_MASKS, (NUM_SHARES-1)*NUM_SHARES/2, localparam: random bits per operation.
- LVL_W, $clog2(RAND_DEPTH+1), localparam: FIFO level width.

Ports:
- ClkCI  in  1  clock, rising edge.
- RstRI  in  1  asynchronous reset, active low.
- InValidSI  in  1  operand pair valid.
- InReadySO  out  1  operand pair accepted.
- LeftDI  in  NUM_SHARES  shares of operand x.
- RightDI  in  NUM_SHARES  shares of operand y.
- RandValidSI  in  1  randomness word valid.
- RandReadySO  out  1  randomness word accepted.
- RandDI  in  NUM_MASKS  fresh randomness word.
- GadLeftDO  out  NUM_SHARES  to gadget LeftDI.
- GadRightDO  out  NUM_SHARES  to gadget RightDI.
- GadRandomDO  out  NUM_MASKS  to gadget RandomDI.
- GadOutDI  in  NUM_SHARES  from gadget OutDO.
- OutValidSO  out  1  result valid.
- OutReadySI  in  1  result consumed.
- OutDO  out  NUM_SHARES  shares of x&y.
- RandLevelDO  out  LVL_W  FIFO occupancy.

Behaviour:
- Reset (RstRI low, asynchronous): FSM=IDLE, FIFO empty, RandLevelDO=0, OutDO=0, OutValidSO=0, InReadySO=0, RandReadySO=0.
- FIFO:
  - RandReadySO = RstRI & (level != RAND_DEPTH).
  - Push on RandValidSI & RandReadySO.
  - Pop on issue.
  - Push and pop in the same cycle: level unchanged, order preserved (FIFO).
  - When full, a push is refused even if a pop occurs that cycle.
  - No bypass: a word pushed in cycle t is poppable from t+1.
- FSM states IDLE, EVAL, HOLD:
  - IDLE: InReadySO = (level != 0). It must not depend on InValidSI. Issue = InValidSI & InReadySO.
    - On issue: GadLeftDO=LeftDI, GadRightDO=RightDI, GadRandomDO=FIFO head; pop; next state EVAL.
    - Otherwise stay IDLE.
  - EVAL: InReadySO=0. GadOutDI is valid this cycle. Capture GadOutDI into OutDO at the next edge; next state HOLD.
  - HOLD: OutValidSO=1, OutDO stable. On OutReadySI go to IDLE, else stay. InReadySO=0.
- Gadget inputs: GadLeftDO, GadRightDO and GadRandomDO are all-zero in every cycle without an issue, so stale shares never recombine in the gadget.
- Latency: input handshake in cycle t, OutValidSO high from cycle t+2. Max throughput 1 op per 3 cycles.
- OutDO keeps its last value after leaving HOLD; it is only rewritten at EVAL→HOLD.
- Reset mid-operation (EVAL or HOLD): result dropped, FIFO contents discarded, return to IDLE.
- InValidSI deasserted before acceptance: no effect, no pop.
- Each randomness word is consumed by exactly one issue and never reused.

Test Plan:
- Reset with RandValidSI=1 held: all outputs 0. After release, RandReadySO=1 and RandLevelDO increments each cycle until 4, then RandReadySO=0.
- NUM_SHARES=2, FIFO holds RandDI=1, LeftDI=2'b10, RightDI=2'b01, InValidSI=1 in cycle t: InReadySO=1, GadLeftDO=2'b10, GadRandomDO=1 in t. OutValidSO=1, OutDO=2'b01 at t+2. Level decrements by 1.
- FIFO empty, InValidSI=1: InReadySO=0 and gadget inputs 0 until one word is pushed; issue occurs the cycle after the push.
- Back-to-back: two ops with OutReadySI=0 for 5 cycles: OutDO held stable, second op not accepted until the cycle after the OutReadySI handshake.
- FIFO full, push and issue in the same cycle: push refused, level 4→3. Next cycle push accepted, level back to 4. Words popped in push order (randomness sequence 1,0,1,1 yields the matching result shares).
- RstRI pulsed low during HOLD: OutValidSO and OutDO drop to 0 immediately, RandLevelDO=0, FSM returns to IDLE.
